sub_spi_slave_ctrl: RTL and testbench
=====================================

# sub_spi_slave_ctrl

SPI slave control stage for the temperature sub-block. It sits directly upstream of the slave shift-register block and drives its `tx_load`, `slave_transfer_shift_en`, `slave_receive_shift_en` and `sub_tx` inputs. It consumes that block's parallel `sub_rx` output. Pad SCLK/CS_N are synchronised into `pclk` and edge-detected to generate one-cycle shift strobes (SPI mode 0). The block also provides a one-byte transmit holding register with a valid/ready handshake and a byte-complete receive strobe.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: byte width; must match the shift block.
- `SYNC_STAGES`, default 2: synchroniser depth for pad inputs, ≥2.

Ports:
- `pclk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high. One clock; every flop resets on `rst` at the `pclk` rising edge.
- `sclk_pad_i` in 1: SPI clock from pad, asynchronous, idles low.
- `cs_n_pad_i` in 1: SPI chip select from pad, asynchronous, active-low.
- `tx_data` in DATA_WIDTH: next byte to transmit.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_ready` out 1: holding register is empty; the byte transfers when `tx_valid && tx_ready`.
- `sub_tx` out DATA_WIDTH: parallel load value for the shift block.
- `tx_load` out 1: one-cycle strobe that loads `sub_tx` into the transmit shifter.
- `slave_transfer_shift_en` out 1: one-cycle strobe that shifts the transmit register left.
- `slave_receive_shift_en` out 1: one-cycle strobe that shifts the receive register and samples SIMO.
- `sub_rx` in DATA_WIDTH: receive shifter contents from the shift block.
- `rx_data` out DATA_WIDTH: last completed received byte.
- `rx_valid` out 1: one-cycle pulse; `rx_data` is new.
- `tx_underrun` out 1: one-cycle pulse; a load occurred with the holding register empty.
- `busy` out 1: a transaction is active (state ≠ IDLE).

## Operation
- The synchronised SCLK and CS_N feed edge detectors: `sclk_rise`, `sclk_fall`, `cs_fall`, `cs_rise`.
- FSM states are IDLE, LOAD and ACTIVE.
- **IDLE**
  - Stay in IDLE until `cs_fall`, then go to LOAD.
  - SCLK edges are ignored.
- **LOAD**
  - Assert `tx_load` for one cycle, clear `bit_cnt`, then go to ACTIVE.
- **ACTIVE**
  - On `sclk_rise`:
    - Assert `slave_receive_shift_en` for one cycle.
    - Increment `bit_cnt` modulo DATA_WIDTH.
    - On wrap from DATA_WIDTH-1 to 0, set `rx_pending`.
  - On `sclk_fall`:
    - If `bit_cnt`==0 and at least one bit has been received, assert `tx_load` (byte boundary).
    - Otherwise, assert `slave_transfer_shift_en`.
  - On `cs_rise`, go to IDLE. The partial byte is discarded and `bit_cnt` is cleared.
- **Receive path**
  - The cycle after `rx_pending` is set, capture `sub_rx` into `rx_data`, pulse `rx_valid`, and clear `rx_pending`.
- **Transmit holding register `hold_q`**
  - `hold_q` is zero whenever empty, and `sub_tx = hold_q`.
  - On a handshake, `hold_q` ← `tx_data` and becomes full.
  - On `tx_load` with `hold_q` full: the shift block loads `hold_q`, then `hold_q` clears to 0 and empty.
  - On `tx_load` with `hold_q` empty: the shift block loads 0x00 and `tx_underrun` pulses.
- **Boundary rules**
  - `tx_load` and a handshake in the same cycle with `hold_q` empty: the load takes 0x00 (underrun), and the new byte is stored for the next load.
  - `cs_rise` coincident with an SCLK edge: `cs_rise` wins and no strobe is issued.
  - `rx_pending` already set when `cs_rise` arrives: `rx_valid` is still issued.
  - `cs_fall` while not in IDLE is impossible by construction and is ignored.
- **Reset**
  - Forces IDLE. Synchroniser flops reset to SCLK=0, CS_N=1.
  - A reset mid-transfer requires a fresh CS_N high→low before the next transaction.
  - All outputs reset to 0 except `tx_ready`=1.

## Timing
- Pad edge to strobe latency: SYNC_STAGES+1 `pclk` cycles.
- All strobes are exactly one cycle wide and mutually exclusive.
- `rx_valid` follows the 8th `slave_receive_shift_en` by exactly 2 cycles: 1 cycle for the shift block to update, 1 for capture.
- `tx_ready` deasserts the cycle after a handshake and reasserts the cycle after the consuming `tx_load`.
- SCLK high and low phases must each be ≥ SYNC_STAGES+2 `pclk` cycles. The minimum `pclk`/SCLK ratio is 8 at default parameters.
- CS_N falling to first SCLK rising must be ≥ SYNC_STAGES+3 `pclk` cycles, so the LOAD state completes before MSB sampling.

## Structure
- Package `sub_spi_pkg` contains:
  - the state enum `spi_slv_state_e` {IDLE, LOAD, ACTIVE};
  - `SPI_DATA_WIDTH`=8;
  - `SPI_SYNC_STAGES`=2.
- Sub-module `sub_sync_edge` (parameterised synchroniser plus rise/fall detector with a reset-value parameter) is instantiated twice, once for SCLK and once for CS_N.
- `bit_cnt` is $clog2(DATA_WIDTH) bits wide.

## Test plan
- Preload 0xA5, drop CS_N, run 8 SCLK cycles with a behavioural shift model → one `tx_load` after `cs_fall`, 7 `slave_transfer_shift_en`, 8 `slave_receive_shift_en`; SOMI bits 1,0,1,0,0,1,0,1; `rx_data`=0x3C when the master sent 0x3C.
- Two back-to-back bytes (0x11 then 0x22, the second provided after the first `tx_ready`) → `tx_load` at the 8th falling edge carries 0x22; two `rx_valid` pulses; `tx_underrun` never asserts.
- Empty holding register at the byte boundary → `sub_tx`=0x00 during `tx_load`, `tx_underrun` pulses once, `tx_ready` stays 1.
- CS_N raised after 5 bits → no `rx_valid`, return to IDLE, `bit_cnt` 0; the next transaction receives a full byte correctly.
- Assert `rst` mid-byte → all outputs at reset values next cycle; SCLK edges ignored until CS_N goes high→low again.
- Handshake in the same cycle as `tx_load` with the holding register empty → load of 0x00 plus underrun, new byte held, `tx_ready`=0.

Source files
------------

// File: rtl/sub_spi_pkg.sv
// Shared types and defaults for the temperature sub-block SPI slave control path.
package sub_spi_pkg;

    localparam int SPI_DATA_WIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } spi_slv_state_e;

endpackage

// File: rtl/sub_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pad input with one-cycle rise/fall detection.
module sub_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   flush_q;
    logic              level;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
            flush_q <= '0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d};
            prev_q  <= sync_q[STAGES-1];
            flush_q <= {flush_q[STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[STAGES-1];

    // Edges are masked until the reset value has fully drained from the chain, so a
    // pad already low/high at reset release never looks like a fresh transition.
    assign rise = flush_q[STAGES] &  level & ~prev_q;
    assign fall = flush_q[STAGES] & ~level &  prev_q;

endmodule

// File: rtl/sub_spi_slave_ctrl.sv
// SPI mode-0 slave control: pad sync/edge detect, load/shift strobes for the shift block,
// one-byte transmit holding register and receive byte capture.
module sub_spi_slave_ctrl
    import sub_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  sclk_pad_i,
    input  logic                  cs_n_pad_i,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] sub_tx,
    output logic                  tx_load,
    output logic                  slave_transfer_shift_en,
    output logic                  slave_receive_shift_en,
    input  logic [DATA_WIDTH-1:0] sub_rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int              CNT_W   = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    spi_slv_state_e        state;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  bits_seen;
    logic                  rx_pending;
    logic [DATA_WIDTH-1:0] hold_q;

    sub_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk  (pclk),
        .rst  (rst),
        .d    (sclk_pad_i),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    sub_sync_edge #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk  (pclk),
        .rst  (rst),
        .d    (cs_n_pad_i),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    assign sub_tx = hold_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state                   <= IDLE;
            bit_cnt                 <= '0;
            bits_seen               <= 1'b0;
            rx_pending              <= 1'b0;
            hold_q                  <= '0;
            tx_ready                <= 1'b1;
            tx_load                 <= 1'b0;
            slave_transfer_shift_en <= 1'b0;
            slave_receive_shift_en  <= 1'b0;
            rx_data                 <= '0;
            rx_valid                <= 1'b0;
            tx_underrun             <= 1'b0;
            busy                    <= 1'b0;
        end else begin
            tx_load                 <= 1'b0;
            slave_transfer_shift_en <= 1'b0;
            slave_receive_shift_en  <= 1'b0;
            rx_valid                <= 1'b0;
            tx_underrun             <= 1'b0;

            case (state)
                IDLE: begin
                    bit_cnt   <= '0;
                    bits_seen <= 1'b0;
                    if (cs_fall) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    tx_load   <= 1'b1;
                    bit_cnt   <= '0;
                    bits_seen <= 1'b0;
                    state     <= ACTIVE;
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        bit_cnt   <= '0;
                        bits_seen <= 1'b0;
                    end else if (sclk_rise) begin
                        slave_receive_shift_en <= 1'b1;
                        bits_seen              <= 1'b1;
                        bit_cnt <= (bit_cnt == CNT_MAX) ? '0 : bit_cnt + 1'b1;
                    end else if (sclk_fall) begin
                        if (bit_cnt == '0 && bits_seen)
                            tx_load <= 1'b1;
                        else
                            slave_transfer_shift_en <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Pending is raised while the wrapping shift strobe is visible, so the capture
            // lands one cycle after the shift block has absorbed the last bit.
            if (rx_pending) begin
                rx_data    <= sub_rx;
                rx_valid   <= 1'b1;
                rx_pending <= 1'b0;
            end else if (slave_receive_shift_en && bit_cnt == '0) begin
                rx_pending <= 1'b1;
            end

            if (tx_load) begin
                tx_underrun <= tx_ready;
                if (!tx_ready) begin
                    hold_q   <= '0;
                    tx_ready <= 1'b1;
                end
            end
            // A handshake needs tx_ready, so it never collides with a consuming load.
            if (tx_valid && tx_ready) begin
                hold_q   <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sub_spi_slave_ctrl.sv
// Directed bench for sub_spi_slave_ctrl with a behavioural shift block and SPI master.
module tb_sub_spi_slave_ctrl;

    localparam int H = 8;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk_pad = 1'b0;
    logic       cs_n_pad = 1'b1;
    logic       simo = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] sub_tx;
    logic       tx_load;
    logic       tsh;
    logic       rsh;
    logic [7:0] sub_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 pclk = ~pclk;

    sub_spi_slave_ctrl #(
        .DATA_WIDTH  (8),
        .SYNC_STAGES (2)
    ) dut (
        .pclk                    (pclk),
        .rst                     (rst),
        .sclk_pad_i              (sclk_pad),
        .cs_n_pad_i              (cs_n_pad),
        .tx_data                 (tx_data),
        .tx_valid                (tx_valid),
        .tx_ready                (tx_ready),
        .sub_tx                  (sub_tx),
        .tx_load                 (tx_load),
        .slave_transfer_shift_en (tsh),
        .slave_receive_shift_en  (rsh),
        .sub_rx                  (sub_rx),
        .rx_data                 (rx_data),
        .rx_valid                (rx_valid),
        .tx_underrun             (tx_underrun),
        .busy                    (busy)
    );

    // Behavioural shift block
    logic [7:0] tx_sr = '0;
    logic [7:0] rx_sr = '0;
    assign sub_rx = rx_sr;

    always @(posedge pclk) begin
        if (tx_load)
            tx_sr <= sub_tx;
        else if (tsh)
            tx_sr <= {tx_sr[6:0], 1'b0};
        if (rsh)
            rx_sr <= {rx_sr[6:0], simo};
    end

    // Strobe counters and logs, sampled mid-cycle
    logic       clr = 1'b0;
    int         n_load, n_tsh, n_rsh, n_rxv, n_under;
    logic [7:0] load_log [8];
    logic [7:0] rx_log [8];

    always @(negedge pclk) begin
        if (clr) begin
            n_load <= 0; n_tsh <= 0; n_rsh <= 0; n_rxv <= 0; n_under <= 0;
        end else begin
            if (tx_load) begin
                if (n_load < 8) load_log[n_load] <= sub_tx;
                n_load <= n_load + 1;
            end
            if (rx_valid) begin
                if (n_rxv < 8) rx_log[n_rxv] <= rx_data;
                n_rxv <= n_rxv + 1;
            end
            if (tsh) n_tsh <= n_tsh + 1;
            if (rsh) n_rsh <= n_rsh + 1;
            if (tx_underrun) n_under <= n_under + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        @(posedge pclk); clr = 1'b1;
        @(posedge pclk); clr = 1'b0;
        @(negedge pclk);
    endtask

    task automatic push(input logic [7:0] d);
        int n = 0;
        while (!tx_ready && n < 200) begin
            @(negedge pclk);
            n++;
        end
        chk("push_ready_timeout", 32'(tx_ready), 32'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
    endtask

    task automatic spi_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            simo = mosi[7-i];
            repeat (H) @(negedge pclk);
            miso[7-i] = tx_sr[7];
            sclk_pad = 1'b1;
            repeat (H) @(negedge pclk);
            sclk_pad = 1'b0;
        end
    endtask

    task automatic txn(input logic pre, input logic [7:0] txb, input logic [7:0] mosi,
                       input int nbits, output logic [7:0] miso);
        if (pre) push(txb);
        clear_counts();
        cs_n_pad = 1'b0;
        repeat (10) @(negedge pclk);
        spi_bits(mosi, nbits, miso);
        repeat (H) @(negedge pclk);
        cs_n_pad = 1'b1;
        repeat (12) @(negedge pclk);
    endtask

    typedef struct {
        logic       pre;
        logic [7:0] txb;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_under;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] miso;
        logic [7:0] miso2;
        int         n;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
        vecs[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};
        vecs[2] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1};
        vecs[3] = '{1'b0, 8'h00, 8'h81, 8'h00, 8'h81, 2};
        vecs[4] = '{1'b1, 8'h69, 8'hC5, 8'h69, 8'hC5, 1};

        repeat (3) @(negedge pclk);
        rst = 1'b0;
        @(posedge pclk); #1;
        chk("reset_strobes", 32'({tx_load, tsh, rsh, rx_valid, tx_underrun, busy, tx_ready}), 32'h01);
        chk("reset_sub_tx", 32'(sub_tx), 32'h00);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        repeat (5) @(negedge pclk);

        // Table-driven single-byte transactions
        for (int i = 0; i < 5; i++) begin
            txn(vecs[i].pre, vecs[i].txb, vecs[i].mosi, 8, miso);
            chk($sformatf("v%0d_miso", i), 32'(miso), 32'(vecs[i].exp_miso));
            chk($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
            chk($sformatf("v%0d_rx_valid_cnt", i), 32'(n_rxv), 32'd1);
            chk($sformatf("v%0d_rsh_cnt", i), 32'(n_rsh), 32'd8);
            chk($sformatf("v%0d_tsh_cnt", i), 32'(n_tsh), 32'd7);
            chk($sformatf("v%0d_load_cnt", i), 32'(n_load), 32'd2);
            chk($sformatf("v%0d_first_load", i), 32'(load_log[0]), 32'(vecs[i].exp_miso));
            chk($sformatf("v%0d_boundary_load", i), 32'(load_log[1]), 32'h00);
            chk($sformatf("v%0d_underrun_cnt", i), 32'(n_under), 32'(vecs[i].exp_under));
            chk($sformatf("v%0d_tx_ready", i), 32'(tx_ready), 32'd1);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        // Back-to-back bytes with the holding register refilled in time
        push(8'h11);
        clear_counts();
        cs_n_pad = 1'b0;
        repeat (10) @(negedge pclk);
        push(8'h22);
        spi_bits(8'hC3, 8, miso);
        push(8'h33);
        spi_bits(8'h96, 8, miso2);
        repeat (H) @(negedge pclk);
        cs_n_pad = 1'b1;
        repeat (12) @(negedge pclk);
        chk("b2b_miso0", 32'(miso), 32'h11);
        chk("b2b_miso1", 32'(miso2), 32'h22);
        chk("b2b_load1", 32'(load_log[1]), 32'h22);
        chk("b2b_load2", 32'(load_log[2]), 32'h33);
        chk("b2b_underrun_cnt", 32'(n_under), 32'd0);
        chk("b2b_rx_valid_cnt", 32'(n_rxv), 32'd2);
        chk("b2b_rx0", 32'(rx_log[0]), 32'hC3);
        chk("b2b_rx1", 32'(rx_log[1]), 32'h96);

        // Handshake coinciding with tx_load while empty
        clear_counts();
        cs_n_pad = 1'b0;
        n = 0;
        while (!tx_load && n < 20) begin
            @(negedge pclk);
            n++;
        end
        chk("same_cycle_load_seen", 32'(tx_load), 32'd1);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(posedge pclk); #1;
        chk("same_cycle_underrun", 32'(tx_underrun), 32'd1);
        chk("same_cycle_tx_ready", 32'(tx_ready), 32'd0);
        chk("same_cycle_sub_tx", 32'(sub_tx), 32'h5A);
        @(negedge pclk);
        tx_valid = 1'b0;
        repeat (8) @(negedge pclk);
        spi_bits(8'h0F, 8, miso);
        repeat (H) @(negedge pclk);
        cs_n_pad = 1'b1;
        repeat (12) @(negedge pclk);
        chk("same_cycle_load0", 32'(load_log[0]), 32'h00);
        chk("same_cycle_load1", 32'(load_log[1]), 32'h5A);
        chk("same_cycle_miso", 32'(miso), 32'h00);
        chk("same_cycle_underrun_cnt", 32'(n_under), 32'd1);
        chk("same_cycle_rx", 32'(rx_log[0]), 32'h0F);

        // Chip select released after 5 bits
        txn(1'b1, 8'h77, 8'hFF, 5, miso);
        chk("partial_rx_valid_cnt", 32'(n_rxv), 32'd0);
        chk("partial_rsh_cnt", 32'(n_rsh), 32'd5);
        chk("partial_busy", 32'(busy), 32'd0);
        chk("partial_bit_cnt", 32'(dut.bit_cnt), 32'd0);
        txn(1'b1, 8'hC3, 8'h5A, 8, miso);
        chk("after_partial_rx", 32'(rx_data), 32'h5A);
        chk("after_partial_rx_cnt", 32'(n_rxv), 32'd1);
        chk("after_partial_miso", 32'(miso), 32'hC3);

        // Reset in the middle of a byte
        push(8'hE7);
        clear_counts();
        cs_n_pad = 1'b0;
        repeat (10) @(negedge pclk);
        spi_bits(8'hFF, 3, miso);
        rst = 1'b1;
        @(posedge pclk); #1;
        chk("midrst_strobes", 32'({tx_load, tsh, rsh, rx_valid, tx_underrun, busy, tx_ready}), 32'h01);
        chk("midrst_sub_tx", 32'(sub_tx), 32'h00);
        chk("midrst_rx_data", 32'(rx_data), 32'h00);
        @(negedge pclk);
        rst = 1'b0;
        clear_counts();
        spi_bits(8'h00, 3, miso);
        repeat (H) @(negedge pclk);
        chk("midrst_ignored_strobes", 32'(n_rsh + n_tsh + n_load), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        cs_n_pad = 1'b1;
        repeat (12) @(negedge pclk);
        txn(1'b1, 8'h3C, 8'hA5, 8, miso);
        chk("after_rst_miso", 32'(miso), 32'h3C);
        chk("after_rst_rx", 32'(rx_data), 32'hA5);
        chk("after_rst_rx_cnt", 32'(n_rxv), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
